irq_controller: RTL

- Interrupt controller between the IO devices (keyboard/switch, VGA, future timers) and the controlpath.
- Latches per-source interrupt edges, masks and prioritises them, and presents a single cpu_irq plus a fixed vector for pc_from_irq.
- Sequences the acknowledge/clear handshake back to the winning device.
- Exposes a small memory-mapped register file on the io bus for mask, pending, active and end-of-interrupt (EOI).

---
 rtl/io_pkg.sv | 20 ++
 rtl/irq_priority_encoder.sv | 24 ++
 rtl/irq_controller.sv | 128 ++++++++++++
 3 files changed

// File: rtl/io_pkg.sv
// Shared io-bus definitions: irq register map, irq FSM states
// and default addresses.
package io_pkg;

  localparam logic [15:0] IRQ_ADDR_BASE = 16'hFF10;

  localparam logic [15:0] IRQ_MASK = 16'd0;
  localparam logic [15:0] IRQ_PEND = 16'd1;
  localparam logic [15:0] IRQ_STAT = 16'd2;
  localparam logic [15:0] IRQ_EOI  = 16'd3;

  localparam int IRQ_ID_W = 3;

  typedef enum logic [1:0] {
    IDLE,
    ASSERT,
    SERVICE
  } irq_state_t;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: lowest set request index wins.
// Reusable for other arbiters on the io bus.
module irq_priority_encoder
  import io_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  output logic                  valid,
  output logic [IRQ_ID_W-1:0]   idx
);

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = IRQ_ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// Edge-latched, masked, fixed-priority interrupt controller
// with ack/EOI handshake and an io-mapped register file.
module irq_controller
  import io_pkg::*;
#(
  parameter int          NUM_SOURCES   = 4,
  parameter logic [15:0] ADDR_BASE     = IRQ_ADDR_BASE,
  parameter logic [15:0] VECTOR_BASE   = 16'h0010,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_SOURCES-1:0] src_irq,
  output logic [NUM_SOURCES-1:0] src_reset_irq,
  output logic                   cpu_irq,
  input  logic                   cpu_ack,
  output logic [15:0]            irq_vector,
  input  logic [15:0]            waddr,
  input  logic [15:0]            wdata,
  input  logic                   wenable,
  input  logic [15:0]            raddr,
  output logic [15:0]            rdata
);

  irq_state_t             state;
  logic [IRQ_ID_W-1:0]    active_id;
  logic [NUM_SOURCES-1:0] mask;
  logic [NUM_SOURCES-1:0] pending;
  logic [NUM_SOURCES-1:0] src_q;

  logic [NUM_SOURCES-1:0] rise;
  logic [NUM_SOURCES-1:0] eligible;
  logic [NUM_SOURCES-1:0] active_oh;
  logic [NUM_SOURCES-1:0] clr;
  logic                   win_valid;
  logic [IRQ_ID_W-1:0]    win_id;
  logic                   ack_take;
  logic [15:0]            woff;
  logic [15:0]            roff;
  logic                   mask_wr;
  logic                   eoi_wr;
  logic                   unused_wdata;

  assign rise      = src_irq & ~src_q;
  assign eligible  = pending & mask;
  assign active_oh = NUM_SOURCES'(1) << active_id;
  assign ack_take  = (state == ASSERT) && cpu_ack;
  assign clr       = ack_take ? active_oh : '0;

  assign woff    = waddr - ADDR_BASE;
  assign roff    = raddr - ADDR_BASE;
  assign mask_wr = wenable && (woff == IRQ_MASK);
  assign eoi_wr  = wenable && (woff == IRQ_EOI);

  assign unused_wdata = ^wdata;

  irq_priority_encoder #(
    .N (NUM_SOURCES)
  ) u_prio (
    .req   (eligible),
    .valid (win_valid),
    .idx   (win_id)
  );

  // A new edge in the ack cycle outranks the clear
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      src_q   <= '0;
      pending <= '0;
      mask    <= '1;
    end else begin
      src_q   <= src_irq;
      pending <= (pending & ~clr) | rise;
      if (mask_wr)
        mask <= wdata[NUM_SOURCES-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      active_id     <= '0;
      cpu_irq       <= 1'b0;
      irq_vector    <= '0;
      src_reset_irq <= '0;
    end else begin
      src_reset_irq <= '0;
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            state      <= ASSERT;
            active_id  <= win_id;
            cpu_irq    <= 1'b1;
            irq_vector <= VECTOR_BASE +
                          VECTOR_STRIDE * {13'd0, win_id};
          end
        end
        ASSERT: begin
          if (cpu_ack) begin
            state         <= SERVICE;
            cpu_irq       <= 1'b0;
            src_reset_irq <= active_oh;
          end
        end
        SERVICE: begin
          if (eoi_wr)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      (roff == IRQ_MASK): rdata[NUM_SOURCES-1:0] = mask;
      (roff == IRQ_PEND): rdata[NUM_SOURCES-1:0] = pending;
      (roff == IRQ_STAT): begin
        rdata[IRQ_ID_W-1:0] = active_id;
        rdata[8]            = (state == SERVICE);
        rdata[9]            = cpu_irq;
      end
      default: rdata = '0;
    endcase
  end

endmodule
